// File: rtl/alu_frame_ctrl.sv
// Command framer between a UART byte stream and an ALU: collects a 5-byte
// command, drives stable operands, waits out ALU latency, returns 3 response bytes.
`timescale 1ns/1ps
module alu_frame_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 1_000_000,
  parameter int unsigned ALU_LAT        = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic [7:0]  RXbuffer,
  input  logic        RXready,
  input  logic        TXbusy,
  output logic [7:0]  TXbuffer,
  output logic        TXstart,
  output logic [1:0]  op,
  output logic [15:0] a,
  output logic [15:0] b,
  output logic        go,
  input  logic [15:0] res,
  input  logic        overflow,
  output logic        frame_err,
  output logic        overrun
);

  localparam int unsigned    TO_W    = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_N   = TO_W'(TIMEOUT_CYCLES);
  localparam logic [2:0]     LAT_N   = 3'(ALU_LAT);
  localparam logic [5:0]     HDR_TAG = 6'b101010;

  localparam logic [3:0] S_IDLE = 4'd0,  S_RXA0 = 4'd1,  S_RXA1 = 4'd2,  S_RXB0 = 4'd3;
  localparam logic [3:0] S_RXB1 = 4'd4,  S_EXEC = 4'd5,  S_TX0  = 4'd6,  S_TX0W = 4'd7;
  localparam logic [3:0] S_TX1  = 4'd8,  S_TX1W = 4'd9,  S_TX2  = 4'd10, S_TX2W = 4'd11;

  logic [3:0]      state_q, state_d;
  logic [1:0]      sh_op_q, sh_op_d;
  logic [15:0]     sh_a_q, sh_a_d;
  logic [7:0]      sh_b_lo_q, sh_b_lo_d;
  logic [1:0]      op_q, op_d;
  logic [15:0]     a_q, a_d, b_q, b_d;
  logic            go_q, go_d;
  logic [2:0]      lat_q, lat_d;
  logic [TO_W-1:0] to_cnt_q, to_cnt_d, to_next;
  logic [15:0]     rsp_res_q, rsp_res_d;
  logic            rsp_ovf_q, rsp_ovf_d;
  logic            err_seen_q, err_seen_d;
  logic [7:0]      tx_buf_q, tx_buf_d;
  logic            tx_start_q, tx_start_d;
  logic            frame_err_q, frame_err_d;
  logic            overrun_q, overrun_d;
  logic            busy_seen_q, busy_seen_d;
  logic            rx_phase, timeout;

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves one unassigned (no latches).
    state_d     = state_q;
    sh_op_d     = sh_op_q;
    sh_a_d      = sh_a_q;
    sh_b_lo_d   = sh_b_lo_q;
    op_d        = op_q;
    a_d         = a_q;
    b_d         = b_q;
    go_d        = 1'b0;
    lat_d       = '0;
    to_cnt_d    = '0;
    rsp_res_d   = rsp_res_q;
    rsp_ovf_d   = rsp_ovf_q;
    err_seen_d  = err_seen_q;
    tx_buf_d    = tx_buf_q;
    tx_start_d  = 1'b0;
    frame_err_d = 1'b0;
    overrun_d   = overrun_q;
    busy_seen_d = busy_seen_q;
    to_next     = RXready ? '0 : to_cnt_q + TO_W'(1);
    rx_phase    = state_q inside {S_RXA0, S_RXA1, S_RXB0, S_RXB1};
    timeout     = rx_phase && !RXready && (to_next == TO_N);

    case (state_q)
      S_IDLE: if (RXready) begin
        if (RXbuffer[7:2] == HDR_TAG) begin
          sh_op_d = RXbuffer[1:0];
          state_d = S_RXA0;
        end else begin
          frame_err_d = 1'b1;
        end
      end
      S_RXA0: if (RXready) begin sh_a_d[7:0]  = RXbuffer; state_d = S_RXA1; end
      S_RXA1: if (RXready) begin sh_a_d[15:8] = RXbuffer; state_d = S_RXB0; end
      S_RXB0: if (RXready) begin sh_b_lo_d    = RXbuffer; state_d = S_RXB1; end
      S_RXB1: if (RXready) begin
        op_d    = sh_op_q;
        a_d     = sh_a_q;
        b_d     = {RXbuffer, sh_b_lo_q};
        go_d    = 1'b1;
        state_d = S_EXEC;
      end
      // lat_q reaches ALU_LAT on the cycle the ALU output is first valid
      S_EXEC: if (lat_q == LAT_N) begin
        rsp_res_d = res;
        rsp_ovf_d = overflow;
        state_d   = S_TX0;
      end else begin
        lat_d = lat_q + 3'd1;
      end
      S_TX0: if (!TXbusy) begin
        tx_buf_d = rsp_res_q[7:0]; tx_start_d = 1'b1; busy_seen_d = 1'b0; state_d = S_TX0W;
      end
      S_TX1: if (!TXbusy) begin
        tx_buf_d = rsp_res_q[15:8]; tx_start_d = 1'b1; busy_seen_d = 1'b0; state_d = S_TX1W;
      end
      S_TX2: if (!TXbusy) begin
        tx_buf_d   = {6'b0, err_seen_q, rsp_ovf_q};
        tx_start_d = 1'b1; busy_seen_d = 1'b0; err_seen_d = 1'b0; state_d = S_TX2W;
      end
      S_TX0W, S_TX1W, S_TX2W: begin
        if (TXbusy) begin
          busy_seen_d = 1'b1;
        end else if (busy_seen_q) begin
          state_d = (state_q == S_TX0W) ? S_TX1 : (state_q == S_TX1W) ? S_TX2 : S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase

    if (rx_phase) to_cnt_d = to_next;
    if (timeout) begin
      frame_err_d = 1'b1;
      state_d     = S_IDLE;
      sh_op_d     = '0;
      sh_a_d      = '0;
      sh_b_lo_d   = '0;
      to_cnt_d    = '0;
    end
    if (RXready && (state_q >= S_EXEC)) overrun_d = 1'b1;
    if (frame_err_d) err_seen_d = 1'b1;
  end

  // NOTE: state registers use non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q     <= S_IDLE;
      sh_op_q     <= '0;
      sh_a_q      <= '0;
      sh_b_lo_q   <= '0;
      op_q        <= '0;
      a_q         <= '0;
      b_q         <= '0;
      go_q        <= 1'b0;
      lat_q       <= '0;
      to_cnt_q    <= '0;
      rsp_res_q   <= '0;
      rsp_ovf_q   <= 1'b0;
      err_seen_q  <= 1'b0;
      tx_buf_q    <= '0;
      tx_start_q  <= 1'b0;
      frame_err_q <= 1'b0;
      overrun_q   <= 1'b0;
      busy_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      sh_op_q     <= sh_op_d;
      sh_a_q      <= sh_a_d;
      sh_b_lo_q   <= sh_b_lo_d;
      op_q        <= op_d;
      a_q         <= a_d;
      b_q         <= b_d;
      go_q        <= go_d;
      lat_q       <= lat_d;
      to_cnt_q    <= to_cnt_d;
      rsp_res_q   <= rsp_res_d;
      rsp_ovf_q   <= rsp_ovf_d;
      err_seen_q  <= err_seen_d;
      tx_buf_q    <= tx_buf_d;
      tx_start_q  <= tx_start_d;
      frame_err_q <= frame_err_d;
      overrun_q   <= overrun_d;
      busy_seen_q <= busy_seen_d;
    end
  end

  assign TXbuffer  = tx_buf_q;
  assign TXstart   = tx_start_q;
  assign op        = op_q;
  assign a         = a_q;
  assign b         = b_q;
  assign go        = go_q;
  assign frame_err = frame_err_q;
  assign overrun   = overrun_q;

endmodule

// File: tb/tb_alu_frame_ctrl.sv
// Bench for alu_frame_ctrl: vector table, directed corner sequences and random
// frames, with a pipelined ALU stub, a UART transmitter model and a response scoreboard.
`timescale 1ns/1ps
module tb_alu_frame_ctrl;

  localparam int T   = 100;
  localparam int LAT = 2;

  logic        CLK = 1'b0;
  logic        RST, RXready, TXbusy, go, TXstart, frame_err, overrun, overflow;
  logic [7:0]  RXbuffer, TXbuffer;
  logic [1:0]  op;
  logic [15:0] a, b, res;

  alu_frame_ctrl #(.TIMEOUT_CYCLES(T), .ALU_LAT(LAT)) dut (
    .CLK(CLK), .RST(RST), .RXbuffer(RXbuffer), .RXready(RXready), .TXbusy(TXbusy),
    .TXbuffer(TXbuffer), .TXstart(TXstart), .op(op), .a(a), .b(b), .go(go),
    .res(res), .overflow(overflow), .frame_err(frame_err), .overrun(overrun)
  );

  always #5 CLK = ~CLK;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ALU stub: two register stages, so results trail operands by LAT cycles
  function automatic logic [16:0] alu_ref(input logic [1:0] o, input logic [15:0] x, input logic [15:0] y);
    case (o)
      2'd0:    return {1'b0, x} + {1'b0, y};
      2'd1:    return {1'b0, x} - {1'b0, y};
      2'd2:    return {x[15], x ^ y};
      default: return {y[0], x | y};
    endcase
  endfunction

  bit          alu_fixed = 1'b0;
  logic [16:0] alu_s1 = '0;
  initial begin res = '0; overflow = 1'b0; end
  always @(posedge CLK) begin
    alu_s1 <= alu_fixed ? 17'h1ABCD : alu_ref(op, a, b);
    {overflow, res} <= alu_s1;
  end

  // UART transmitter model and output monitors
  logic [7:0] exp_q[$];
  int   tx_seen = 0, busy_cnt = 0, fe_seen = 0, fe_exp = 0;
  logic mdl_busy = 1'b0, ext_busy = 1'b0;
  logic prev_start = 1'b0, prev_busy = 1'b0, prev_fe = 1'b0, prev_go = 1'b0;
  logic [7:0] last_buf = '0;
  assign TXbusy = mdl_busy | ext_busy;

  always @(posedge CLK) begin
    if (TXstart) begin
      tx_seen++;
      check("txstart_back_to_back", 32'(prev_start), 0);
      check("txstart_while_busy", 32'(prev_busy), 0);
      if (exp_q.size() == 0) check("tx_unexpected_byte", 32'(TXbuffer), 32'hFFFF_FFFF);
      else                   check("tx_byte", 32'(TXbuffer), 32'(exp_q.pop_front()));
      busy_cnt = $urandom_range(1, 4);
    end
    mdl_busy <= (busy_cnt > 0);
    if (busy_cnt > 0) busy_cnt--;
    prev_start <= TXstart;
    prev_busy  <= TXbusy;
    if (RST) last_buf = '0;
    else if (TXstart) last_buf = TXbuffer;
    else if (TXbuffer !== last_buf) check("txbuffer_stable", 32'(TXbuffer), 32'(last_buf));
    if (!RST && frame_err) begin fe_seen++; check("frame_err_width", 32'(prev_fe), 0); end
    if (!RST && go) check("go_width", 32'(prev_go), 0);
    prev_fe <= frame_err;
    prev_go <= go;
  end

  bit err_flag = 1'b0;

  task automatic tick();
    @(posedge CLK); #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic send_byte(input logic [7:0] v);
    RXbuffer = v; RXready = 1'b1;
    tick();
    RXready = 1'b0;
  endtask

  task automatic bad_header(input logic [7:0] h);
    send_byte(h);
    check("bad_hdr_frame_err", 32'(frame_err), 1);
    fe_exp++; err_flag = 1'b1;
    tick();
    check("bad_hdr_pulse_end", 32'(frame_err), 0);
  endtask

  // Sends a valid frame (gap < 0: random gaps) and queues the expected response
  task automatic send_frame(input logic [7:0] hdr, input logic [15:0] fa, input logic [15:0] fb, input int gap);
    logic [7:0]  fbytes[5];
    logic [1:0]  op0;
    logic [15:0] a0, b0;
    logic [16:0] r;
    fbytes = '{hdr, fa[7:0], fa[15:8], fb[7:0], fb[15:8]};
    op0 = op; a0 = a; b0 = b;
    r = alu_fixed ? 17'h1ABCD : alu_ref(hdr[1:0], fa, fb);
    exp_q.push_back(r[7:0]);
    exp_q.push_back(r[15:8]);
    exp_q.push_back({6'b0, err_flag, r[16]});
    err_flag = 1'b0;
    for (int i = 0; i < 5; i++) begin
      if (i > 0) idle(gap < 0 ? $urandom_range(0, 3) : gap);
      send_byte(fbytes[i]);
      if (i < 4) begin
        check("rx_hold_a", 32'(a), 32'(a0));
        if (i == 3) begin
          check("rx_hold_b", 32'(b), 32'(b0));
          check("rx_hold_op", 32'(op), 32'(op0));
        end
      end
    end
    check("go_after_last", 32'(go), 1);
    check("op_applied", 32'(op), 32'(hdr[1:0]));
    check("a_applied", 32'(a), 32'(fa));
    check("b_applied", 32'(b), 32'(fb));
    tick();
    check("go_one_cycle", 32'(go), 0);
  endtask

  // Waits for three response bytes; optionally holds TXbusy or injects a byte in TX1W
  task automatic wait_resp(input int hold, input bit inj);
    int start, cyc;
    bit first, injected;
    start = tx_seen; cyc = 1; first = 1'b1; injected = 1'b0;
    ext_busy = (hold > 0);
    while (!((tx_seen == start + 3) && !TXbusy) && cyc < 400) begin
      tick(); cyc++;
      if (cyc > hold) ext_busy = 1'b0;
      if (TXstart && first) begin
        check("tx_latency", 32'(cyc >= LAT + 1), 1);
        first = 1'b0;
      end
      if (inj && !injected && tx_seen == start + 2) begin
        RXbuffer = 8'hA5; RXready = 1'b1;
        tick(); cyc++;
        RXready = 1'b0; injected = 1'b1;
        check("overrun_set", 32'(overrun), 1);
      end
    end
    ext_busy = 1'b0;
    check("resp_byte_count", 32'(tx_seen - start), 3);
    idle(2);
    check("resp_queue_drained", 32'(exp_q.size()), 0);
  endtask

  typedef struct {
    logic [7:0]  hdr;
    logic [15:0] va, vb;
    bit          fixed;
    bit          exp_err;
    logic [1:0]  exp_op;
  } vec_t;

  vec_t vecs[6];

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [15:0] a0, b0;
    logic [7:0]  h;
    vecs[0] = '{hdr: 8'hAA, va: 16'h1234, vb: 16'h5678, fixed: 1, exp_err: 0, exp_op: 2'd2};
    vecs[1] = '{hdr: 8'h3F, va: 16'h0000, vb: 16'h0000, fixed: 0, exp_err: 1, exp_op: 2'd0};
    vecs[2] = '{hdr: 8'hA9, va: 16'h0003, vb: 16'h0005, fixed: 0, exp_err: 0, exp_op: 2'd1};
    vecs[3] = '{hdr: 8'h55, va: 16'h0000, vb: 16'h0000, fixed: 0, exp_err: 1, exp_op: 2'd0};
    vecs[4] = '{hdr: 8'hAB, va: 16'hF0F0, vb: 16'h0F01, fixed: 0, exp_err: 0, exp_op: 2'd3};
    vecs[5] = '{hdr: 8'hA8, va: 16'hFFFF, vb: 16'h0001, fixed: 0, exp_err: 0, exp_op: 2'd0};

    RST = 1'b1; RXready = 1'b0; RXbuffer = '0;
    idle(2);
    check("rst_TXbuffer", 32'(TXbuffer), 0);
    check("rst_TXstart", 32'(TXstart), 0);
    check("rst_op", 32'(op), 0);
    check("rst_a", 32'(a), 0);
    check("rst_b", 32'(b), 0);
    check("rst_go", 32'(go), 0);
    check("rst_frame_err", 32'(frame_err), 0);
    check("rst_overrun", 32'(overrun), 0);
    RST = 1'b0;
    idle(2);

    for (int i = 0; i < 6; i++) begin
      alu_fixed = vecs[i].fixed;
      if (vecs[i].exp_err) begin
        bad_header(vecs[i].hdr);
      end else begin
        send_frame(vecs[i].hdr, vecs[i].va, vecs[i].vb, 1);
        check("vec_op", 32'(op), 32'(vecs[i].exp_op));
        wait_resp(vecs[i].fixed ? 6 : 0, 1'b0);
      end
    end
    alu_fixed = 1'b0;

    // Partial frame dropped after T idle cycles
    a0 = a; b0 = b;
    send_byte(8'hA8);
    send_byte(8'h11);
    idle(T - 1);
    check("timeout_not_early", 32'(frame_err), 0);
    tick();
    check("timeout_frame_err", 32'(frame_err), 1);
    fe_exp++; err_flag = 1'b1;
    tick();
    check("timeout_pulse_end", 32'(frame_err), 0);
    check("timeout_a_kept", 32'(a), 32'(a0));
    check("timeout_b_kept", 32'(b), 32'(b0));
    send_frame(8'hA9, 16'h8000, 16'h0001, 0);
    wait_resp(0, 1'b0);

    // Bytes one cycle before, and exactly on, the terminal count
    send_frame(8'hAA, 16'h1357, 16'h2468, T - 2);
    wait_resp(0, 1'b0);
    send_frame(8'hAB, 16'h00F0, 16'h0F00, T - 1);
    wait_resp(0, 1'b0);
    check("boundary_no_err", 32'(fe_seen), 32'(fe_exp));

    // Byte arriving while the response is in flight
    check("overrun_clear_before", 32'(overrun), 0);
    send_frame(8'hA8, 16'h7FFF, 16'h7FFF, 0);
    wait_resp(2, 1'b1);
    check("overrun_sticky", 32'(overrun), 1);

    // Asynchronous reset in TX1W
    send_frame(8'hA9, 16'h4444, 16'h1111, 0);
    n = tx_seen;
    for (int c = 0; c < 400 && tx_seen < n + 2; c++) tick();
    check("reach_tx1w", 32'(tx_seen - n), 2);
    check("overrun_still_set", 32'(overrun), 1);
    #2 RST = 1'b1;
    #1;
    check("arst_TXbuffer", 32'(TXbuffer), 0);
    check("arst_TXstart", 32'(TXstart), 0);
    check("arst_op", 32'(op), 0);
    check("arst_a", 32'(a), 0);
    check("arst_b", 32'(b), 0);
    check("arst_go", 32'(go), 0);
    check("arst_frame_err", 32'(frame_err), 0);
    check("arst_overrun", 32'(overrun), 0);
    exp_q.delete(); err_flag = 1'b0;
    tick();
    RST = 1'b0;
    n = tx_seen;
    idle(50);
    check("no_tx_after_reset", 32'(tx_seen), 32'(n));
    send_frame(8'hAA, 16'hCAFE, 16'hBEEF, 0);
    wait_resp(0, 1'b0);

    // Random frames against the reference model
    for (int k = 0; k < 30; k++) begin
      if ($urandom_range(0, 6) == 0) begin
        h = 8'($urandom);
        if (h[7:2] == 6'b101010) h[7] = 1'b0;
        bad_header(h);
        idle($urandom_range(0, 3));
      end else begin
        h = {6'b101010, 2'($urandom)};
        send_frame(h, 16'($urandom), 16'($urandom), -1);
        wait_resp($urandom_range(0, 3), 1'b0);
      end
    end

    idle(3);
    check("frame_err_count", 32'(fe_seen), 32'(fe_exp));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
